// File: rtl/uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// uart_reg_bridge
//
// Parses a byte stream from the UART receiver into register-bus transactions
// and returns a response byte stream to the UART transmitter.
//
//   Write frame : 'W' addr_hi addr_lo data_hi data_lo  -> response 'A'
//   Read frame  : 'R' addr_hi addr_lo                  -> response data_hi data_lo
//   Other first byte                                   -> response 'N'
//
// A partial frame left idle for P_TIMEOUT cycles is abandoned silently.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid  received byte and its one-cycle strobe
//   o_tx_data, o_tx_valid  response byte and valid
//   i_tx_ready             transmitter accepts on valid&ready
//   o_addr, o_wdata        register bus address / write data
//   o_wen                  register bus write enable (one-cycle pulse)
//   i_q                    register bus read data (registered by the map)
//   o_busy                 high whenever a frame or response is in progress
// -----------------------------------------------------------------------------
module uart_reg_bridge #(
   parameter int P_TIMEOUT = 500000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic [15:0] o_addr,
   output logic [15:0] o_wdata,
   output logic        o_wen,
   input  logic [15:0] i_q,
   output logic        o_busy
);

   localparam int             CW      = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
   localparam logic [CW-1:0]  TO_LAST = CW'(P_TIMEOUT - 1);

   localparam logic [7:0] CMD_W  = 8'h57;
   localparam logic [7:0] CMD_R  = 8'h52;
   localparam logic [7:0] RSP_A  = 8'h41;
   localparam logic [7:0] RSP_N  = 8'h4E;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_H,
      S_ADDR_L,
      S_DATA_H,
      S_DATA_L,
      S_WRITE,
      S_RD_WAIT0,
      S_RD_WAIT1,
      S_TX_ACK,
      S_TX_NAK,
      S_TX_HI,
      S_TX_LO
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic            is_write;
   logic [15:0]     rdata;
   logic [CW-1:0]   cnt;
   logic            mid_frame;
   logic            timeout;

   // Only the header/payload collection states are subject to the inter-byte
   // timeout; a byte arriving in the expiry cycle cancels the expiry.
   assign mid_frame = (state == S_ADDR_H) || (state == S_ADDR_L) ||
                      (state == S_DATA_H) || (state == S_DATA_L);
   assign timeout   = mid_frame && !i_rx_valid && (cnt == TO_LAST);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: state_nx is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (i_rx_valid) begin
               if ((i_rx_data == CMD_W) || (i_rx_data == CMD_R)) state_nx = S_ADDR_H;
               else                                               state_nx = S_TX_NAK;
            end
         end
         S_ADDR_H:   if (i_rx_valid) state_nx = S_ADDR_L;
         S_ADDR_L:   if (i_rx_valid) state_nx = is_write ? S_DATA_H : S_RD_WAIT0;
         S_DATA_H:   if (i_rx_valid) state_nx = S_DATA_L;
         S_DATA_L:   if (i_rx_valid) state_nx = S_WRITE;
         S_WRITE:    state_nx = S_TX_ACK;
         S_RD_WAIT0: state_nx = S_RD_WAIT1;
         S_RD_WAIT1: state_nx = S_TX_HI;
         S_TX_ACK:   if (i_tx_ready) state_nx = S_IDLE;
         S_TX_NAK:   if (i_tx_ready) state_nx = S_IDLE;
         S_TX_HI:    if (i_tx_ready) state_nx = S_TX_LO;
         S_TX_LO:    if (i_tx_ready) state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
      if (timeout) state_nx = S_IDLE;
   end

   // -------------------------------------------------------------------------
   // Outputs decoded from state. Because the response byte is a pure function
   // of the state and rdata, it is inherently stable while stalled, and
   // o_wen / o_tx_valid drop the instant reset forces the state to IDLE.
   // -------------------------------------------------------------------------
   always_comb begin
      o_tx_data  = 8'h00;
      o_tx_valid = 1'b0;
      unique case (state)
         S_TX_ACK: begin o_tx_data = RSP_A;       o_tx_valid = 1'b1; end
         S_TX_NAK: begin o_tx_data = RSP_N;       o_tx_valid = 1'b1; end
         S_TX_HI:  begin o_tx_data = rdata[15:8]; o_tx_valid = 1'b1; end
         S_TX_LO:  begin o_tx_data = rdata[7:0];  o_tx_valid = 1'b1; end
         default:  ;
      endcase
   end

   assign o_wen  = (state == S_WRITE);
   assign o_busy = (state != S_IDLE);

   // -------------------------------------------------------------------------
   // Datapath: command type, address, write data, read data, timeout counter
   // -------------------------------------------------------------------------
   // NOTE: every datapath register is reset; the register bus must present a
   // defined address and data right out of reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         is_write <= 1'b0;
         o_addr   <= 16'h0000;
         o_wdata  <= 16'h0000;
         rdata    <= 16'h0000;
         cnt      <= '0;
      end else begin
         if (i_rx_valid) begin
            unique case (state)
               S_IDLE:   is_write      <= (i_rx_data == CMD_W);
               S_ADDR_H: o_addr[15:8]  <= i_rx_data;
               S_ADDR_L: o_addr[7:0]   <= i_rx_data;
               S_DATA_H: o_wdata[15:8] <= i_rx_data;
               S_DATA_L: o_wdata[7:0]  <= i_rx_data;
               default:  ;
            endcase
         end

         // The map registers i_q one cycle after the address settles, so it
         // is valid during RD_WAIT1.
         if (state == S_RD_WAIT1) rdata <= i_q;

         if (!mid_frame || i_rx_valid || timeout) cnt <= '0;
         else                                     cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_bridge
//
// Directed bench for uart_reg_bridge. A small register-map model answers
// reads with one-cycle registered data. Table vectors cover complete frames;
// hand-written sequences cover timeout, expiry-cycle byte, transmit stall and
// mid-frame reset.
// -----------------------------------------------------------------------------
module tb_uart_reg_bridge;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        wen;
   logic [15:0] q;
   logic        busy;

   uart_reg_bridge #(.P_TIMEOUT(TO)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_rx_data  (rx_data),
      .i_rx_valid (rx_valid),
      .o_tx_data  (tx_data),
      .o_tx_valid (tx_valid),
      .i_tx_ready (tx_ready),
      .o_addr     (addr),
      .o_wdata    (wdata),
      .o_wen      (wen),
      .i_q        (q),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register map model: write on o_wen, read data registered from o_addr.
   logic [15:0] mem [16];
   always @(posedge clk) begin
      if (wen) mem[addr[3:0]] <= wdata;
      q <= mem[addr[3:0]];
   end

   // Bus / response monitor, sampled mid-cycle.
   int          wen_count;
   int          wen_cyc;
   int          tx_first;
   logic [15:0] wen_addr;
   logic [15:0] wen_data;
   logic [7:0]  txq [$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (wen) begin
            wen_count = wen_count + 1;
            wen_cyc   = cyc;
            wen_addr  = addr;
            wen_data  = wdata;
         end
         if (tx_valid && tx_first < 0) tx_first = cyc;
         if (tx_valid && tx_ready) txq.push_back(tx_data);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   int last_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = b;
      last_cyc = cyc;
   endtask

   task automatic idle_cyc();
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic clear_log();
      wen_count = 0;
      tx_first  = -1;
      txq.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " o_wen"},      wen,      0);
      check({tag, " o_tx_valid"}, tx_valid, 0);
      check({tag, " o_tx_data"},  tx_data,  0);
      check({tag, " o_addr"},     addr,     0);
      check({tag, " o_wdata"},    wdata,    0);
      check({tag, " o_busy"},     busy,     0);
   endtask

   typedef struct packed {
      int          n;      // frame length in bytes
      logic [39:0] bytes;  // frame bytes, first byte in the MSBs
      int          ntx;    // number of response bytes
      logic [15:0] txb;    // response bytes, first in the MSBs
      logic        wen;    // a bus write is expected
      logic [15:0] addr;   // expected o_addr after the frame (and at o_wen)
      logic [15:0] wdata;  // expected o_wdata at o_wen
      int          lat;    // cycles from last rx strobe to first o_tx_valid
   } vec_t;

   vec_t vecs [7];

   task automatic run_vec(input vec_t v, input int k);
      int t0;
      clear_log();
      for (int i = 0; i < v.n; i++) send(v.bytes[39-8*i -: 8]);
      t0 = last_cyc;
      repeat (15) idle_cyc();
      check($sformatf("vec%0d tx count", k), txq.size(), v.ntx);
      for (int i = 0; i < v.ntx; i++)
         if (i < txq.size()) check($sformatf("vec%0d tx byte %0d", k, i), txq[i], v.txb[15-8*i -: 8]);
      check($sformatf("vec%0d wen count", k), wen_count, v.wen ? 1 : 0);
      if (v.wen) begin
         check($sformatf("vec%0d wen addr", k),    wen_addr,     v.addr);
         check($sformatf("vec%0d wen data", k),    wen_data,     v.wdata);
         check($sformatf("vec%0d wen latency", k), wen_cyc - t0, 1);
      end
      check($sformatf("vec%0d tx latency", k), tx_first - t0, v.lat);
      check($sformatf("vec%0d o_addr hold", k), addr, v.addr);
      check($sformatf("vec%0d busy after", k),  busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      int bad;

      for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
      mem[6] = 16'h5A5A;

      //         n  bytes              ntx txb       wen  addr      wdata     lat
      vecs[0] = '{5, 40'h57_00_04_12_34, 1, 16'h4100, 1'b1, 16'h0004, 16'h1234, 2};
      vecs[1] = '{3, 40'h52_00_04_00_00, 2, 16'h1234, 1'b0, 16'h0004, 16'h0000, 3};
      vecs[2] = '{1, 40'h33_00_00_00_00, 1, 16'h4E00, 1'b0, 16'h0004, 16'h0000, 1};
      vecs[3] = '{5, 40'h57_00_09_BE_EF, 1, 16'h4100, 1'b1, 16'h0009, 16'hBEEF, 2};
      vecs[4] = '{3, 40'h52_00_09_00_00, 2, 16'hBEEF, 1'b0, 16'h0009, 16'h0000, 3};
      vecs[5] = '{3, 40'h52_00_06_00_00, 2, 16'h5A5A, 1'b0, 16'h0006, 16'h0000, 3};
      vecs[6] = '{5, 40'h57_00_02_AB_CD, 1, 16'h4100, 1'b1, 16'h0002, 16'hABCD, 2};

      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b1;
      clear_log();

      // Reset state, during and after reset.
      #12;
      check_reset_outputs("in reset");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("after reset");

      // Complete frames.
      for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

      // Partial frame abandoned after TO idle cycles; expires exactly then.
      clear_log();
      send(8'h57);
      send(8'h00);
      t0 = last_cyc;
      repeat (TO) idle_cyc();
      @(negedge clk);
      check("timeout busy at expiry cycle", busy, 1);
      check("timeout cycle index", cyc - t0, TO);
      idle_cyc();
      @(negedge clk);
      check("timeout busy after expiry", busy, 0);
      repeat (3) idle_cyc();
      check("timeout no wen", wen_count, 0);
      check("timeout no response", txq.size(), 0);
      run_vec(vecs[5], 6);

      // A byte arriving in the expiry cycle is accepted.
      clear_log();
      send(8'h57);
      send(8'h00);
      repeat (TO - 1) idle_cyc();
      send(8'h0C);
      send(8'h00);
      send(8'h01);
      repeat (15) idle_cyc();
      check("expiry byte wen count", wen_count, 1);
      check("expiry byte wen addr",  wen_addr,  16'h000C);
      check("expiry byte wen data",  wen_data,  16'h0001);
      check("expiry byte tx count",  txq.size(), 1);
      if (txq.size() > 0) check("expiry byte tx ack", txq[0], 8'h41);

      // Transmit stall: data_hi held for 10 cycles, rx bytes ignored.
      tx_ready = 1'b0;
      clear_log();
      send(8'h52);
      send(8'h00);
      send(8'h04);
      t0 = last_cyc;
      repeat (3) idle_cyc();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!(tx_valid === 1'b1 && tx_data === 8'h12)) bad++;
         send(8'h57);
      end
      idle_cyc();
      tx_ready = 1'b1;
      repeat (10) idle_cyc();
      check("stall first valid latency", tx_first - t0, 3);
      check("stall cycles not holding data_hi", bad, 0);
      check("stall tx count", txq.size(), 2);
      if (txq.size() == 2) begin
         check("stall tx hi", txq[0], 8'h12);
         check("stall tx lo", txq[1], 8'h34);
      end
      check("stall no wen", wen_count, 0);
      check("stall busy after", busy, 0);

      // Reset in the middle of a write frame.
      clear_log();
      send(8'h57);
      send(8'h00);
      send(8'h02);
      send(8'h12);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_reset_outputs("mid-frame reset");
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) idle_cyc();
      check("reset no wen", wen_count, 0);
      check("reset no response", txq.size(), 0);
      run_vec(vecs[6], 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
